freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Multi-channel gated edge counter (frequency meter) for board bring-up and clock/IO diagnostics.
- Counts rising edges of N_CH asynchronous input signals over a programmable gate window timed by i_clk.
- Latches per-channel results and exposes the selected channel's count plus its top nibble for a seven-segment decoder.
- Successor to free-running per-clock debug counters: adds channels, a defined gate, single-shot/continuous modes, saturation and overflow flags.

Parameters:
- N_CH, 4, number of measured input channels (1..16)
- CNT_W, 24, width of each edge counter/result (8..32)
- GATE_CYCLES, 50000000, gate window length in i_clk cycles (>=2; 1 s at 50 MHz)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_sig  in  N_CH  asynchronous signals to measure
- i_start  in  1  start request, sampled each cycle
- i_continuous  in  1  1 = re-arm automatically after each result
- i_sel  in  $clog2(N_CH) (min 1)  channel shown on o_count/o_nibble
- o_count  out  CNT_W  latched result of channel i_sel (combinational mux of result regs)
- o_nibble  out  4  o_count[CNT_W-1 -: 4]
- o_ovf  out  N_CH  per-channel overflow flag of last latched window
- o_busy  out  1  high in ARM/GATE/LATCH
- o_valid  out  1  one-cycle pulse when new results latched
- o_max  out  CNT_W  peak-hold value of channel i_sel (see Optional Feature)
- i_clr_max  in  1  clears peak-hold registers

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all counters, results, o_ovf, o_valid, o_busy, o_max, sync flops = 0.
- Per channel: SYNC_STAGES synchroniser, then prev flop; edge = sync & ~prev. Max measurable rate < f_clk/2.
- FSM IDLE -> ARM when i_start=1. ARM (1 cycle): clear edge counters, gate timer, ovf accumulators. ARM -> GATE.
- GATE: exactly GATE_CYCLES cycles; each cycle, channel counter += edge. At CNT_W all-ones counter saturates; that channel's ovf accumulator sets sticky. Last GATE cycle's edge is counted.
- GATE -> LATCH: copy counters to results, ovf accumulators to o_ovf; o_valid = 1 in the cycle after LATCH edge (single pulse).
- LATCH -> ARM if i_continuous=1 at LATCH, else IDLE.
- Latency: i_start sampled high at edge k -> o_valid high in cycle k+GATE_CYCLES+2, results stable from then until next LATCH.
- i_start while busy: ignored. i_start and i_continuous both low in IDLE: hold results.
- i_continuous dropped mid-window: current window completes, then IDLE.
- i_sel out of range (N_CH not power of 2): o_count = 0, o_nibble = 0.
- Reset mid-window: abort immediately, all state to reset values; no o_valid.
- Results never partially updated: all channels latch in the same cycle.

Optional Feature:
- FREQ_METER_PEAK_HOLD_EN defined: per-channel peak registers; at each LATCH, peak = max(peak, new result); i_clr_max=1 clears all peaks to 0 (clear wins over simultaneous LATCH update); o_max = peak[i_sel].
- Not defined: no peak registers; o_max tied to 0; i_clr_max ignored.

Decomposition:
- freq_meter_pkg: state enum (IDLE, ARM, GATE, LATCH), gate timer width function (clog2 of GATE_CYCLES), saturating-increment function.
- Sub-module edge_sync: SYNC_STAGES synchroniser + rising-edge pulse, instantiated per channel via generate.

Test Plan (GATE_CYCLES=100, CNT_W=8, N_CH=4):
- ch0 toggled every 2 cycles (period 4), free-running before i_start pulse -> o_valid at k+102; o_count(sel=0) in {24,25}, o_ovf[0]=0, o_busy high k+1..k+101.
- ch1 toggled every cycle (period 2) with CNT_W=5 -> count saturates at 31, o_ovf[1]=1; next window with ch1 idle -> count 0, o_ovf[1]=0.
- i_continuous=1, ch2 period 10 -> o_valid pulses every 102 cycles, each result 10 (±1); drop i_continuous -> exactly one more o_valid, then o_busy=0.
- i_start re-asserted mid-GATE -> no restart; single o_valid at original k+102.
- Assert i_rst_n=0 at GATE cycle 50 -> all outputs 0 immediately; no o_valid afterwards until new i_start.
- With FREQ_METER_PEAK_HOLD_EN: windows with ch3 counts 20 then 7 -> o_max=20; i_clr_max pulse -> o_max=0; next window count 7 -> o_max=7.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the freq_meter block.
//   state_e      : measurement sequencer states
//   gate_timer_w : width of the gate down-counter for a given window length
//   sat_inc      : conditional increment that sticks at a ceiling value
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // The timer counts GATE_CYCLES-1 down to 0, so clog2(GATE_CYCLES) bits hold it.
  function automatic int gate_timer_w(input int gate_cycles);
    return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    if (inc && (val != max_val)) return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Per-channel input conditioning: SYNC_STAGES-deep synchroniser followed by a
// previous-value flop; o_edge is a one-cycle pulse for each rising edge of i_sig.
// Ports: i_clk, i_rst_n (async active-low), i_sig (asynchronous), o_edge.
module freq_meter_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_sig};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Multi-channel gated edge counter. Counts rising edges of each i_sig channel
// over a GATE_CYCLES window, latches all channels together and shows the
// selected channel on o_count / o_nibble.
// Ports: i_clk, i_rst_n (async active-low), i_sig[N_CH], i_start, i_continuous,
//        i_sel, i_clr_max; o_count, o_nibble, o_ovf[N_CH], o_busy, o_valid, o_max.
// Build option: FREQ_METER_PEAK_HOLD_EN adds per-channel peak-hold registers
// behind o_max; without it o_max is 0 and i_clr_max is ignored.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for i_start, results held
// ST_ARM   | one cycle: clear counters, ovf accumulators, load timer
// ST_GATE  | GATE_CYCLES cycles of edge counting
// ST_LATCH | copy counters/ovf to result registers, pick ARM or IDLE
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 50000000,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_CH-1:0]  i_sig,
  input  logic             i_start,
  input  logic             i_continuous,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_clr_max,
  output logic [CNT_W-1:0] o_count,
  output logic [3:0]       o_nibble,
  output logic [N_CH-1:0]  o_ovf,
  output logic             o_busy,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_max
);

  localparam int               TMR_W   = gate_timer_w(GATE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0] edge_w;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    freq_meter_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_sig  (i_sig[g]),
      .o_edge (edge_w[g])
    );
  end

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmr_done;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] res_q [N_CH];
  logic [CNT_W-1:0] res_d [N_CH];
  logic [N_CH-1:0]  acc_ovf_q, acc_ovf_d;
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [31:0]      inc32;
  logic [CNT_W-1:0] count_mux;

  assign tmr_done = (tmr_q == '0);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_ARM;
      ST_ARM:   state_d = ST_GATE;
      ST_GATE:  if (tmr_done) state_d = ST_LATCH;
      ST_LATCH: state_d = i_continuous ? ST_ARM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy  = (state_q != ST_IDLE);
    valid_d = (state_q == ST_LATCH);
  end

  // Datapath: timer, counters, ovf accumulators, result registers
  always_comb begin
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    acc_ovf_d = acc_ovf_q;
    ovf_d     = ovf_q;
    inc32     = '0;
    case (state_q)
      ST_ARM: begin
        tmr_d     = TMR_W'(GATE_CYCLES - 1);
        acc_ovf_d = '0;
        for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
      end
      ST_GATE: begin
        if (!tmr_done) tmr_d = tmr_q - TMR_W'(1);
        for (int i = 0; i < N_CH; i++) begin
          inc32    = sat_inc(32'(cnt_q[i]), 32'(CNT_MAX), edge_w[i]);
          cnt_d[i] = inc32[CNT_W-1:0];
          // Overflow means an edge was lost because the counter was already full.
          if (edge_w[i] && (cnt_q[i] == CNT_MAX)) acc_ovf_d[i] = 1'b1;
        end
      end
      ST_LATCH: begin
        res_d = cnt_q;
        ovf_d = acc_ovf_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q     <= '0;
      acc_ovf_q <= '0;
      ovf_q     <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      tmr_q     <= tmr_d;
      acc_ovf_q <= acc_ovf_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
    end
  end

  // Compare-based select so an out-of-range i_sel reads 0 instead of indexing past the array.
  always_comb begin
    count_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (i_sel == SEL_W'(i)) count_mux = res_q[i];
    end
  end

  assign o_count  = count_mux;
  assign o_nibble = count_mux[CNT_W-1 -: 4];
  assign o_ovf    = ovf_q;
  assign o_valid  = valid_q;

`ifdef FREQ_METER_PEAK_HOLD_EN
  logic [CNT_W-1:0] peak_q [N_CH];
  logic [CNT_W-1:0] peak_d [N_CH];
  logic [CNT_W-1:0] max_mux;

  // Clear has priority over a simultaneous latch update.
  always_comb begin
    peak_d = peak_q;
    if (i_clr_max) begin
      for (int i = 0; i < N_CH; i++) peak_d[i] = '0;
    end else if (state_q == ST_LATCH) begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_q[i] > peak_q[i]) peak_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CH; i++) peak_q[i] <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  always_comb begin
    max_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (i_sel == SEL_W'(i)) max_mux = peak_q[i];
    end
  end

  assign o_max = max_mux;
`else
  logic unused_clr_max;
  assign unused_clr_max = i_clr_max;
  assign o_max          = '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with GATE_CYCLES=100. A main instance
// (N_CH=4, CNT_W=8) and a narrow instance (N_CH=3, CNT_W=5) share stimulus;
// the narrow one exercises saturation/overflow and out-of-range i_sel.
// Expected o_max values depend on FREQ_METER_PEAK_HOLD_EN.
module tb_freq_meter;

`ifdef FREQ_METER_PEAK_HOLD_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_cont, i_clr_max;
  logic [1:0] sel;
  logic [2:0] sig_gen = '0;
  logic       sig3;
  logic [3:0] sig_all;

  logic [7:0] o_count;
  logic [3:0] o_nibble;
  logic [3:0] o_ovf;
  logic       o_busy, o_valid;
  logic [7:0] o_max;

  logic [4:0] s_count;
  logic [3:0] s_nibble;
  logic [2:0] s_ovf;
  logic       s_busy, s_valid;
  logic [4:0] s_max;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int cyc      = 0;
  int per [3]  = '{0, 0, 0};
  int ph  [3]  = '{0, 0, 0};

  assign sig_all = {sig3, sig_gen};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_valid) n_valid++;

  // Free-running square waves on channels 0..2 (period per[c] cycles, 0 = idle low).
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (per[c] == 0) begin
        sig_gen[c] = 1'b0;
        ph[c]      = 0;
      end else begin
        ph[c]      = (ph[c] + 1) % per[c];
        sig_gen[c] = (ph[c] < per[c] / 2);
      end
    end
  end

  freq_meter #(.N_CH(4), .CNT_W(8), .GATE_CYCLES(100), .SYNC_STAGES(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig_all), .i_start(i_start),
    .i_continuous(i_cont), .i_sel(sel), .i_clr_max(i_clr_max),
    .o_count(o_count), .o_nibble(o_nibble), .o_ovf(o_ovf), .o_busy(o_busy),
    .o_valid(o_valid), .o_max(o_max)
  );

  freq_meter #(.N_CH(3), .CNT_W(5), .GATE_CYCLES(100), .SYNC_STAGES(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig_all[2:0]), .i_start(i_start),
    .i_continuous(i_cont), .i_sel(sel), .i_clr_max(i_clr_max),
    .o_count(s_count), .o_nibble(s_nibble), .o_ovf(s_ovf), .o_busy(s_busy),
    .o_valid(s_valid), .o_max(s_max)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_sel(input logic [1:0] v);
    sel = v;
    #1;
  endtask

  task automatic start_window(output int t0);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    t0      = cyc;
    i_start = 1'b0;
    check_val("start_busy", o_busy, 1);
  endtask

  // Exactly n pulses on channel 3, starting a few cycles into the gate.
  task automatic burst3(input int n);
    repeat (3) @(negedge clk);
    repeat (n) begin
      @(negedge clk) sig3 = 1'b1;
      @(negedge clk) sig3 = 1'b0;
    end
  endtask

  task automatic wait_valid(input string tag, input int t0, input bit busy_after, output int tv);
    bit found     = 1'b0;
    bit busy_prev = 1'b0;
    tv = cyc;
    for (int i = 0; i < 400 && !found; i++) begin
      busy_prev = o_busy;
      @(posedge clk);
      #1;
      if (o_valid) begin
        found = 1'b1;
        tv    = cyc;
      end
    end
    check_val({tag, "_seen"}, found, 1);
    check_val({tag, "_lat"}, tv - t0, 102);
    check_val({tag, "_busy_pre"}, busy_prev, 1);
    check_val({tag, "_busy_at"}, o_busy, busy_after);
    check_val({tag, "_sat_valid"}, s_valid, 1);
    @(posedge clk);
    #1;
    check_val({tag, "_valid_once"}, o_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, tv, nv;
    rst_n = 1'b0; i_start = 1'b0; i_cont = 1'b0; i_clr_max = 1'b0;
    sel = 2'd0; sig3 = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_valid", o_valid, 0);
    check_val("rst_count", o_count, 0);
    check_val("rst_ovf", o_ovf, 0);
    check_val("rst_max", o_max, 0);
    rst_n = 1'b1;
    per[0] = 4; per[1] = 2; per[2] = 10;
    repeat (20) @(negedge clk);

    // Window A: ch0 period 4, ch1 period 2, ch2 period 10, ch3 20 pulses
    start_window(t0);
    burst3(20);
    wait_valid("winA", t0, 1'b0, tv);
    set_sel(2'd0);
    check_val("a_ch0_in_24_25", (o_count == 8'd24) || (o_count == 8'd25), 1);
    check_val("a_ch0_nib", o_nibble, 1);
    set_sel(2'd1);
    check_val("a_ch1", o_count, 50);
    check_val("a_ch1_nib", o_nibble, 3);
    check_val("a_sat_ch1", s_count, 31);
    set_sel(2'd2);
    check_val("a_ch2", o_count, 10);
    check_val("a_sat_ch2", s_count, 10);
    set_sel(2'd3);
    check_val("a_ch3", o_count, 20);
    check_val("a_sat_oor_cnt", s_count, 0);
    check_val("a_sat_oor_nib", s_nibble, 0);
    check_val("a_max", o_max, PEAK ? 20 : 0);
    check_val("a_ovf", o_ovf, 0);
    check_val("a_sat_ovf", s_ovf, 3'b010);

    // Window B: ch1 idle, ch3 7 pulses, i_start re-asserted mid-gate
    per[1] = 0;
    start_window(t0);
    burst3(7);
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    wait_valid("winB", t0, 1'b0, tv);
    set_sel(2'd1);
    check_val("b_ch1", o_count, 0);
    check_val("b_sat_ch1", s_count, 0);
    check_val("b_sat_ovf", s_ovf, 0);
    set_sel(2'd3);
    check_val("b_ch3", o_count, 7);
    check_val("b_max", o_max, PEAK ? 20 : 0);
    nv = n_valid;
    repeat (120) @(posedge clk);
    #1;
    check_val("b_no_restart", n_valid, nv);
    check_val("b_idle_busy", o_busy, 0);
    check_val("b_hold_ch3", o_count, 7);

    // Peak clear, then a window with 7 pulses on ch3
    @(negedge clk) i_clr_max = 1'b1;
    @(posedge clk);
    #1;
    i_clr_max = 1'b0;
    check_val("clr_max", o_max, 0);
    start_window(t0);
    burst3(7);
    wait_valid("winC", t0, 1'b0, tv);
    check_val("c_ch3", o_count, 7);
    check_val("c_max", o_max, PEAK ? 7 : 0);

    // Continuous mode on ch2 period 10, then drop i_continuous
    set_sel(2'd2);
    i_cont = 1'b1;
    nv = n_valid;
    start_window(t0);
    wait_valid("cont1", t0, 1'b1, tv);
    check_val("cont1_ch2", o_count, 10);
    t0 = tv;
    wait_valid("cont2", t0, 1'b1, tv);
    check_val("cont2_ch2", o_count, 10);
    i_cont = 1'b0;
    t0 = tv;
    wait_valid("cont3", t0, 1'b0, tv);
    check_val("cont3_ch2", o_count, 10);
    repeat (150) @(posedge clk);
    #1;
    check_val("cont_total_valid", n_valid - nv, 3);
    check_val("cont_end_busy", o_busy, 0);

    // Reset in the middle of a window
    start_window(t0);
    repeat (50) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", o_busy, 0);
    check_val("mid_rst_valid", o_valid, 0);
    check_val("mid_rst_count", o_count, 0);
    check_val("mid_rst_ovf", o_ovf, 0);
    check_val("mid_rst_max", o_max, 0);
    check_val("mid_rst_sat_cnt", s_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nv = n_valid;
    repeat (150) @(posedge clk);
    #1;
    check_val("post_rst_no_valid", n_valid, nv);
    check_val("post_rst_busy", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
